cmv300_capture_ctrl: RTL and testbench

Frame-capture sequencer for the CMV300 parallel 8-bit readout path. On a start request it pulses FRAME_REQ, tracks Line_valid/Data_valid to count pixels, lines and frames, and gates sensor pixels into the downstream block-throttled FIFO. It flags FIFO overflow, malformed lines and missing frames. It runs entirely in the CVM300_CLK_OUT domain, and its counters and state are exported for ILA probing.

---
 rtl/cmv300_capture_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cmv300_capture_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmv300_capture_ctrl.sv
// Frame-capture sequencer for the CMV300 8-bit parallel readout: requests a frame,
// counts pixels/lines/frames and gates sensor pixels into the downstream FIFO.
module cmv300_capture_ctrl #(
    parameter int unsigned LINE_PIXELS = 648,
    parameter int unsigned FRAME_LINES = 488,
    parameter int unsigned REQ_PULSE   = 4,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clr,
    input  logic        line_valid,
    input  logic        data_valid,
    input  logic [7:0]  pix_in,
    input  logic        fifo_full,
    output logic        frame_req,
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        line_err,
    output logic        timeout,
    output logic [9:0]  pixel_cnt,
    output logic [9:0]  line_cnt,
    output logic [15:0] frame_cnt,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_LINE = 3'd2,
        LINE      = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam logic [9:0]  PIX_MAX   = 10'(LINE_PIXELS);
    localparam logic [9:0]  LAST_LINE = 10'(FRAME_LINES - 1);
    localparam logic [15:0] REQ_LAST  = 16'(REQ_PULSE - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] req_cnt;
    logic [15:0] wait_cnt;

    logic pix_take;
    logic pix_room;
    logic pix_write;
    logic pix_drop;
    logic pix_extra;
    logic line_end;
    logic short_line;
    logic enter_req;
    logic tmo_hit;

    // WAIT_LINE shares the pixel path so a pixel on the line_valid rising cycle is not lost.
    assign pix_take   = line_valid && data_valid && (state_q == WAIT_LINE || state_q == LINE);
    assign pix_room   = pixel_cnt < PIX_MAX;
    assign pix_write  = pix_take && pix_room && !fifo_full;
    assign pix_drop   = pix_take && pix_room && fifo_full;
    assign pix_extra  = pix_take && !pix_room;
    assign line_end   = (state_q == LINE) && !line_valid;
    assign short_line = line_end && (pixel_cnt != PIX_MAX);
    assign enter_req  = (state_q == IDLE) && start;
    assign tmo_hit    = (state_q == WAIT_LINE) && !line_valid && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start) state_d = REQ;
            REQ:       if (req_cnt == REQ_LAST) state_d = WAIT_LINE;
            WAIT_LINE: begin
                if (line_valid) begin
                    state_d = LINE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_d = ERR;
                end
            end
            LINE: begin
                if (!line_valid) begin
                    state_d = (line_cnt == LAST_LINE) ? DONE : WAIT_LINE;
                end
            end
            DONE:      state_d = IDLE;
            ERR:       if (clr) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        state = state_q;
    end

    // frame_req is registered from the next state so it is high exactly while in REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_cnt      <= '0;
            wait_cnt     <= '0;
            frame_req    <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            pixel_cnt    <= '0;
            line_cnt     <= '0;
            frame_cnt    <= '0;
        end else begin
            req_cnt    <= (state_q == REQ) ? req_cnt + 16'd1 : 16'd0;
            wait_cnt   <= (state_q == WAIT_LINE) ? wait_cnt + 16'd1 : 16'd0;
            frame_req  <= (state_d == REQ);
            fifo_wr_en <= pix_write;
            if (pix_write) begin
                fifo_wr_data <= pix_in;
            end
            if (enter_req) begin
                pixel_cnt <= '0;
                line_cnt  <= '0;
            end else if (line_end) begin
                pixel_cnt <= '0;
                line_cnt  <= line_cnt + 10'd1;
            end else if (pix_take && pix_room) begin
                pixel_cnt <= pixel_cnt + 10'd1;
            end
            if (state_q == DONE) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    // Sticky flags: a new set condition wins over clr in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            line_err <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (pix_drop) begin
                overflow <= 1'b1;
            end else if (clr || enter_req) begin
                overflow <= 1'b0;
            end
            if (pix_extra || short_line) begin
                line_err <= 1'b1;
            end else if (clr || enter_req) begin
                line_err <= 1'b0;
            end
            if (tmo_hit) begin
                timeout <= 1'b1;
            end else if (clr) begin
                timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmv300_capture_ctrl.sv
// Bench for cmv300_capture_ctrl: a cycle-level behavioural model of the capture
// sequence is compared against every DUT output on each falling clock edge.
module tb_cmv300_capture_ctrl;

    localparam int LP = 8;
    localparam int FL = 3;
    localparam int RP = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        clr;
    logic        line_valid;
    logic        data_valid;
    logic [7:0]  pix_in;
    logic        fifo_full;
    logic        frame_req;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        line_err;
    logic        timeout;
    logic [9:0]  pixel_cnt;
    logic [9:0]  line_cnt;
    logic [15:0] frame_cnt;
    logic [2:0]  state;

    cmv300_capture_ctrl #(
        .LINE_PIXELS(LP),
        .FRAME_LINES(FL),
        .REQ_PULSE(RP),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .clr(clr),
        .line_valid(line_valid),
        .data_valid(data_valid),
        .pix_in(pix_in),
        .fifo_full(fifo_full),
        .frame_req(frame_req),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .busy(busy),
        .done(done),
        .overflow(overflow),
        .line_err(line_err),
        .timeout(timeout),
        .pixel_cnt(pixel_cnt),
        .line_cnt(line_cnt),
        .frame_cnt(frame_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit compare_on = 1'b0;
    int dut_writes = 0;
    int req_hi = 0;
    int done_n = 0;

    // Model phases follow the externally visible state numbering.
    int         m_state, m_req_n, m_wait_n, m_pix, m_line, m_writes;
    logic [15:0] m_frame;
    bit         m_ovf, m_lerr, m_tmo, m_wr_en, m_nxt_wr;
    logic [7:0] m_wr_data;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_req_n = 0; m_wait_n = 0; m_pix = 0; m_line = 0;
            m_frame = '0; m_ovf = 0; m_lerr = 0; m_tmo = 0; m_wr_en = 0; m_wr_data = '0;
        end else begin
            m_nxt_wr = 0;
            if (clr) begin
                m_ovf = 0; m_lerr = 0; m_tmo = 0;
            end
            case (m_state)
                0: if (start) begin
                    m_state = 1; m_req_n = 0; m_ovf = 0; m_lerr = 0; m_pix = 0; m_line = 0;
                end
                1: begin
                    m_req_n++;
                    if (m_req_n == RP) begin m_state = 2; m_wait_n = 0; end
                end
                2, 3: begin
                    if (line_valid) begin
                        m_state = 3;
                        if (data_valid) begin
                            if (m_pix < LP) begin
                                m_pix++;
                                if (fifo_full) m_ovf = 1; else m_nxt_wr = 1;
                            end else begin
                                m_lerr = 1;
                            end
                        end
                    end else if (m_state == 2) begin
                        m_wait_n++;
                        if (m_wait_n == TO) begin m_tmo = 1; m_state = 5; end
                    end else begin
                        if (m_pix != LP) m_lerr = 1;
                        m_line++;
                        m_pix = 0;
                        if (m_line == FL) m_state = 4;
                        else begin m_state = 2; m_wait_n = 0; end
                    end
                end
                4: begin m_frame = m_frame + 16'd1; m_state = 0; end
                5: if (clr) m_state = 0;
                default: m_state = 0;
            endcase
            m_wr_en = m_nxt_wr;
            if (m_nxt_wr) begin
                m_wr_data = pix_in;
                m_writes++;
            end
        end
    end

    always @(negedge clk) begin
        if (compare_on) begin
            check_output("state", 32'(state), 32'(m_state));
            check_output("busy", 32'(busy), 32'(m_state != 0));
            check_output("done", 32'(done), 32'(m_state == 4));
            check_output("frame_req", 32'(frame_req), 32'(m_state == 1));
            check_output("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
            if (m_wr_en) check_output("fifo_wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
            check_output("overflow", 32'(overflow), 32'(m_ovf));
            check_output("line_err", 32'(line_err), 32'(m_lerr));
            check_output("timeout", 32'(timeout), 32'(m_tmo));
            check_output("pixel_cnt", 32'(pixel_cnt), 32'(m_pix));
            check_output("line_cnt", 32'(line_cnt), 32'(m_line));
            check_output("frame_cnt", 32'(frame_cnt), 32'(m_frame));
            if (fifo_wr_en === 1'b1) dut_writes++;
            if (frame_req === 1'b1) req_hi++;
            if (done === 1'b1) done_n++;
        end
    end

    task automatic apply_stimulus(input logic s, input logic c, input logic lv, input logic dv,
                                  input logic [7:0] px, input logic ff);
        start = s; clr = c; line_valid = lv; data_valid = dv; pix_in = px; fifo_full = ff;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    // Three-line frame; fifo_full covers pixels ff_lo..ff_hi of line ff_line.
    task automatic send_frame(input int len0, input int len1, input int len2, input int ff_line,
                              input int ff_lo, input int ff_hi, input bit rand_dv, input bit busy_start);
        int lens[3];
        int idx;
        logic dv, ff, st;
        lens = '{len0, len1, len2};
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        idle(4 + int'($urandom_range(0, 3)));
        for (int i = 0; i < 3; i++) begin
            idx = 0;
            while (idx < lens[i]) begin
                dv = rand_dv ? ($urandom_range(0, 3) != 0) : 1'b1;
                ff = dv && (i == ff_line) && (idx >= ff_lo) && (idx <= ff_hi);
                st = busy_start && (idx == 2);
                apply_stimulus(st, 1'b0, 1'b1, dv, 8'($urandom), ff);
                if (dv) idx++;
            end
            idle(1);
            if (i == 2) apply_stimulus(busy_start, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            else idle(int'($urandom_range(0, 3)));
        end
        idle(3);
    endtask

    int w0, mw0, r0, d0, lv_left;
    logic lv;

    initial begin
        reset = 1'b1;
        start = 0; clr = 0; line_valid = 0; data_valid = 0; pix_in = '0; fifo_full = 0;
        m_writes = 0;
        repeat (3) @(negedge clk);
        check_output("reset_state", 32'(state), 32'd0);
        check_output("reset_frame_req", 32'(frame_req), 32'd0);
        check_output("reset_wr_en", 32'(fifo_wr_en), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        compare_on = 1'b1;

        $display("[TB] full frame");
        w0 = dut_writes; mw0 = m_writes; r0 = req_hi; d0 = done_n;
        send_frame(8, 8, 8, -1, 0, 0, 1'b0, 1'b0);
        check_output("full_writes", 32'(dut_writes - w0), 32'd24);
        check_output("full_model_writes", 32'(m_writes - mw0), 32'd24);
        check_output("full_req_cycles", 32'(req_hi - r0), 32'd4);
        check_output("full_done_pulses", 32'(done_n - d0), 32'd1);
        check_output("full_frame_cnt", 32'(frame_cnt), 32'd1);
        check_output("full_overflow", 32'(overflow), 32'd0);
        check_output("full_line_err", 32'(line_err), 32'd0);

        $display("[TB] backpressure");
        w0 = dut_writes; mw0 = m_writes;
        send_frame(8, 8, 8, 0, 2, 3, 1'b0, 1'b0);
        check_output("bp_writes", 32'(dut_writes - w0), 32'd22);
        check_output("bp_model_writes", 32'(m_writes - mw0), 32'd22);
        check_output("bp_overflow", 32'(overflow), 32'd1);
        check_output("bp_line_err", 32'(line_err), 32'd0);
        check_output("bp_frame_cnt", 32'(frame_cnt), 32'd2);

        $display("[TB] short and long lines");
        w0 = dut_writes; d0 = done_n;
        send_frame(8, 6, 10, -1, 0, 0, 1'b1, 1'b0);
        check_output("sl_writes", 32'(dut_writes - w0), 32'd22);
        check_output("sl_line_err", 32'(line_err), 32'd1);
        check_output("sl_overflow", 32'(overflow), 32'd0);
        check_output("sl_line_cnt", 32'(line_cnt), 32'd3);
        check_output("sl_done_pulses", 32'(done_n - d0), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        check_output("idle_clr_line_err", 32'(line_err), 32'd0);

        $display("[TB] timeout");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        idle(23);
        check_output("tmo_still_waiting", 32'(state), 32'd2);
        check_output("tmo_not_yet", 32'(timeout), 32'd0);
        idle(1);
        check_output("tmo_state_err", 32'(state), 32'd5);
        check_output("tmo_flag", 32'(timeout), 32'd1);
        idle(2);
        check_output("tmo_err_holds", 32'(state), 32'd5);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        check_output("tmo_clr_state", 32'(state), 32'd0);
        check_output("tmo_clr_flag", 32'(timeout), 32'd0);

        $display("[TB] reset mid-line");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        idle(4);
        repeat (8) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0);
        idle(2);
        repeat (5) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0);
        check_output("pre_reset_pixel_cnt", 32'(pixel_cnt), 32'd5);
        check_output("pre_reset_line_cnt", 32'(line_cnt), 32'd1);
        check_output("pre_reset_wr_en", 32'(fifo_wr_en), 32'd1);
        #2;
        compare_on = 1'b0;
        start = 0; clr = 0; line_valid = 0; data_valid = 0; fifo_full = 0;
        reset = 1'b1;
        #1;
        check_output("rst_frame_req", 32'(frame_req), 32'd0);
        check_output("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        check_output("rst_pixel_cnt", 32'(pixel_cnt), 32'd0);
        check_output("rst_line_cnt", 32'(line_cnt), 32'd0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_output("rst_state", 32'(state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_on = 1'b1;

        $display("[TB] clean frame with start while busy");
        w0 = dut_writes; r0 = req_hi; d0 = done_n;
        send_frame(8, 8, 8, -1, 0, 0, 1'b0, 1'b1);
        check_output("clean_writes", 32'(dut_writes - w0), 32'd24);
        check_output("clean_req_cycles", 32'(req_hi - r0), 32'd4);
        check_output("clean_done_pulses", 32'(done_n - d0), 32'd1);
        check_output("clean_frame_cnt", 32'(frame_cnt), 32'd1);
        check_output("clean_state", 32'(state), 32'd0);

        $display("[TB] line data while idle");
        w0 = dut_writes;
        repeat (3) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        end
        check_output("idle_writes", 32'(dut_writes - w0), 32'd0);
        check_output("idle_state", 32'(state), 32'd0);
        check_output("idle_pixel_cnt", 32'(pixel_cnt), 32'd0);
        check_output("idle_line_cnt", 32'(line_cnt), 32'd3);

        $display("[TB] random soak");
        lv = 1'b0;
        lv_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (lv_left == 0) begin
                lv = ~lv;
                lv_left = lv ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 26));
            end
            lv_left--;
            apply_stimulus($urandom_range(0, 24) == 0, $urandom_range(0, 39) == 0, lv,
                           $urandom_range(0, 4) != 0, 8'($urandom), $urandom_range(0, 9) == 0);
        end
        idle(5);
        compare_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
